// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: requester IDs and the
// read-return tag carried alongside each access through the SRAM latency.
package mem_arb_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_READ_LATENCY = 2;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Fixed-depth shift register of read tags; the last stage names the owner of
// the data currently on the SRAM read bus.
module read_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = DEF_READ_LATENCY + 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH-1:0] tag_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the single SRAM port: fixed A priority with a
// starvation override for B, registered memory-side signals, tagged returns.
module sram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [31:0]           a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [31:0]           b_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  input  logic [31:0]           mem_read_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starve;
  logic          any_gnt;
  logic          win_we;
  rd_tag_t       tag_in, tag_out;

  assign starve = (starve_cnt == CW'(STARVE_LIMIT));

  // B wins only when starved or when A is idle; A otherwise has priority.
  always_comb begin
    b_gnt = b_req & (starve | ~a_req);
    a_gnt = a_req & ~b_gnt;
  end

  assign any_gnt      = a_gnt | b_gnt;
  assign win_we       = b_gnt ? b_we : a_we;
  assign tag_in.valid = any_gnt & ~win_we;
  assign tag_in.id    = b_gnt ? REQ_B : REQ_A;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!b_req || b_gnt) begin
      starve_cnt <= '0;
    end else if (!starve) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr         <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      if (any_gnt) begin
        mem_addr         <= b_gnt ? b_addr  : a_addr;
        mem_write_data   <= b_gnt ? b_wdata : a_wdata;
        mem_write_enable <= win_we;
      end
    end
  end

  // One extra stage over the SRAM latency covers the address register.
  read_tag_pipe #(.DEPTH(READ_LATENCY + 1)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag_out.valid & (tag_out.id == REQ_A);
      b_rvalid <= tag_out.valid & (tag_out.id == REQ_B);
      if (tag_out.valid && tag_out.id == REQ_A) a_rdata <= mem_read_data;
      if (tag_out.valid && tag_out.id == REQ_B) b_rdata <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: an SRAM model, a transaction-level reference
// (memory map + return queue), a grant table, directed corners, random traffic.
module tb_sram_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 8;

  logic        clk, reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  sram_arbiter #(.READ_LATENCY(LAT), .STARVE_LIMIT(STARVE), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  // ---------------- SRAM model (2-cycle pipelined read) ----------------
  logic [31:0] sram    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sr_d1, sr_d2;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_0000;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram.exists(a) ? sram[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  always @(posedge clk) begin
    sr_d1 <= sram_rd(mem_addr);
    sr_d2 <= sr_d1;
    if (mem_write_enable) sram[mem_addr] = mem_write_data;
  end
  assign mem_read_data = sr_d2;

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    sram[a]    = d;
    ref_mem[a] = d;
  endtask

  // ---------------- Reference model / continuous checker ----------------
  typedef struct {
    int          cyc;
    logic        id;
    logic [31:0] data;
  } ret_t;

  ret_t        rq[$];
  int          m_cnt;
  logic [31:0] m_addr, m_wdata, m_ard, m_brd, w_addr, w_data;
  logic        m_we, w_we, g_a, g_b, e_arv, e_brv;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_write_data, 32'h0);
      chk1("rst_mem_we", mem_write_enable, 1'b0);
      chk1("rst_a_rvalid", a_rvalid, 1'b0);
      chk1("rst_b_rvalid", b_rvalid, 1'b0);
      chk("rst_a_rdata", a_rdata, 32'h0);
      chk("rst_b_rdata", b_rdata, 32'h0);
      rq.delete();
      m_cnt = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
      m_ard = '0; m_brd = '0; g_a = 1'b0; g_b = 1'b0;
    end else begin
      g_b = b_req && (m_cnt == STARVE || !a_req);
      g_a = a_req && !g_b;
      chk1("a_gnt", a_gnt, g_a);
      chk1("b_gnt", b_gnt, g_b);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_write_data", mem_write_data, m_wdata);
      chk1("mem_write_enable", mem_write_enable, m_we);
      e_arv = 1'b0; e_brv = 1'b0;
      if (rq.size() != 0 && rq[0].cyc == cyc) begin
        if (rq[0].id) begin e_brv = 1'b1; m_brd = rq[0].data; end
        else          begin e_arv = 1'b1; m_ard = rq[0].data; end
        void'(rq.pop_front());
      end
      chk1("a_rvalid", a_rvalid, e_arv);
      chk1("b_rvalid", b_rvalid, e_brv);
      chk("a_rdata", a_rdata, m_ard);
      chk("b_rdata", b_rdata, m_brd);
      chk1("dual_rvalid", a_rvalid & b_rvalid, 1'b0);
      if (g_a || g_b) begin
        w_addr = g_b ? b_addr : a_addr;
        w_data = g_b ? b_wdata : a_wdata;
        w_we   = g_b ? b_we : a_we;
        m_addr = w_addr; m_wdata = w_data; m_we = w_we;
        if (w_we) ref_mem[w_addr] = w_data;
        else rq.push_back('{cyc + LAT + 2, g_b, ref_rd(w_addr)});
      end else begin
        m_we = 1'b0;
      end
      if (b_req && !g_b) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : m_cnt;
      else               m_cnt = 0;
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic drive(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    @(posedge clk); #1;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  typedef struct packed {
    logic ar, aw, br, bw, ea, eb;
  } vec_t;

  vec_t tbl [8];
  int   n0, seen;

  initial begin
    reset = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Grant table from a cleared starvation counter: {ar,aw,br,bw,exp_a,exp_b}
    tbl[0] = 6'b0000_00;
    tbl[1] = 6'b1000_10;
    tbl[2] = 6'b0010_01;
    tbl[3] = 6'b1010_10;
    tbl[4] = 6'b0000_00;
    tbl[5] = 6'b1010_10;
    tbl[6] = 6'b0010_01;
    tbl[7] = 6'b1100_10;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ar, tbl[i].aw, 32'(i * 4), 32'hA000_0000 + 32'(i),
            tbl[i].br, tbl[i].bw, 32'h40 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      @(negedge clk);
      chk1("tbl_a_gnt", a_gnt, tbl[i].ea);
      chk1("tbl_b_gnt", b_gnt, tbl[i].eb);
    end
    idle(6);

    // Single A read
    preload(32'h40, 32'hDEAD_BEEF);
    drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk1("rd_a_gnt", a_gnt, 1'b1);
    idle(1); @(negedge clk); chk("rd_mem_addr", mem_addr, 32'h40);
    idle(2); @(negedge clk); chk1("rd_early_rvalid", a_rvalid, 1'b0);
    idle(1); @(negedge clk);
    chk1("rd_a_rvalid", a_rvalid, 1'b1);
    chk("rd_a_rdata", a_rdata, 32'hDEAD_BEEF);
    idle(3);

    // Write then read the same address on consecutive grants
    drive(1, 1, 32'h80, 32'h1234_5678, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 32'h80, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk1("wr_mem_we_n1", mem_write_enable, 1'b1);
    chk("wr_mem_wdata", mem_write_data, 32'h1234_5678);
    idle(1); @(negedge clk); chk1("wr_mem_we_n2", mem_write_enable, 1'b0);
    idle(2); @(negedge clk); chk1("wr_no_rvalid", a_rvalid, 1'b0);
    idle(1); @(negedge clk);
    chk1("wr_rd_rvalid", a_rvalid, 1'b1);
    chk("wr_rd_rdata", a_rdata, 32'h1234_5678);
    idle(3);

    // Priority with starvation override
    for (int k = 1; k <= 10; k++) begin
      drive(1, 0, 32'h200 + 32'(k * 4), 32'h0, 1, 0, 32'h300, 32'h0);
      @(negedge clk);
      chk1("prio_a_gnt", a_gnt, k != 9);
      chk1("prio_b_gnt", b_gnt, k == 9);
    end
    idle(6);

    // Interleaved returns
    preload(32'h10, 32'h1111_0010);
    preload(32'h20, 32'h2222_0020);
    preload(32'h30, 32'h3333_0030);
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    drive(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int t = 3; t <= 6; t++) begin
      idle(1); @(negedge clk);
      chk1("il_a_rvalid", a_rvalid, t == 4 || t == 6);
      chk1("il_b_rvalid", b_rvalid, t == 5);
      if (t == 4) chk("il_a_rdata0", a_rdata, 32'h1111_0010);
      if (t == 5) chk("il_b_rdata", b_rdata, 32'h2222_0020);
      if (t == 6) chk("il_a_rdata1", a_rdata, 32'h3333_0030);
    end

    // Idle: address holds, no strobes, no returns
    for (int t = 0; t < 10; t++) begin
      idle(1); @(negedge clk);
      chk1("idle_mem_we", mem_write_enable, 1'b0);
      chk("idle_mem_addr", mem_addr, 32'h30);
      chk1("idle_rvalid", a_rvalid | b_rvalid, 1'b0);
    end

    // Reset while a read is in flight
    drive(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; a_req = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk1("rstmid_rvalid", a_rvalid, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    seen = 0;
    repeat (8) begin
      idle(1); @(negedge clk);
      if (a_rvalid) seen++;
    end
    chk("rstmid_no_rvalid", 32'(seen), 32'h0);

    // Random traffic; requests held until the model grants them
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (!a_req || g_a) begin
        a_req   = ($urandom % 4) != 0;
        a_we    = $urandom % 2;
        a_addr  = {26'h0, 4'($urandom % 16), 2'b00};
        a_wdata = $urandom;
      end
      if (!b_req || g_b) begin
        b_req   = ($urandom % 3) != 0;
        b_we    = $urandom % 2;
        b_addr  = {26'h0, 4'($urandom % 16), 2'b00};
        b_wdata = $urandom;
      end
    end
    idle(8);
    chk("rq_drained", 32'(rq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
